// File: rtl/fp_adder_arbiter_pkg.sv
// Shared types and helpers for the round-robin floating-point adder arbiter.
package fp_adder_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, RESPOND} state_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
  } fp_add_flags_t;

  function automatic int next_rr_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fp_adder_arbiter_fp_add.sv
// Combinational FP adder; subnormal inputs/results flush to zero, NaN results are canonical.
module floating_point_adder #(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1,
  parameter int ROUNDING_BITS    = 3,
  localparam int W = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         subtract,
  output logic [W-1:0] out,
  output logic         invalid,
  output logic         overflow,
  output logic         underflow
);
  localparam int EW = EXPONENT_WIDTH;
  localparam int MW = MANTISSA_WIDTH;
  localparam int RB = ROUNDING_BITS;
  localparam int SW = MW + 1 + RB;
  localparam logic [EW-1:0]        EXP_MAX = '1;
  localparam logic signed [EW+1:0] EXP_ONE = (EW+2)'(1);

  logic                 sa, sb, sx, swap, eff_sub, a_nan, b_nan, a_inf, b_inf, round_up;
  logic [EW-1:0]        ea, eb, ex, ey;
  logic [MW-1:0]        fa, fb, fx, fy, frac;
  logic [SW-1:0]        mx, my, my_sh, norm;
  logic [2*SW-1:0]      sh_full;
  logic [SW:0]          sum;
  logic [RB-1:0]        grs, grs_rest;
  logic [MW+1:0]        mant_r;
  logic signed [EW+1:0] exp_r;
  int                   d, lz;

  always_comb begin
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    sb      = sb ^ subtract;
    a_nan   = (ea == EXP_MAX) && (fa != '0);
    b_nan   = (eb == EXP_MAX) && (fb != '0);
    a_inf   = (ea == EXP_MAX) && (fa == '0);
    b_inf   = (eb == EXP_MAX) && (fb == '0);
    eff_sub = sa ^ sb;

    // Order by magnitude so the subtraction below never goes negative.
    swap = {eb, fb} > {ea, fa};
    sx   = swap ? sb : sa;
    ex   = swap ? eb : ea;
    fx   = swap ? fb : fa;
    ey   = swap ? ea : eb;
    fy   = swap ? fa : fb;
    mx   = (ex == '0) ? '0 : {1'b1, fx, {RB{1'b0}}};
    my   = (ey == '0) ? '0 : {1'b1, fy, {RB{1'b0}}};

    d = int'(ex) - int'(ey);
    if (d > SW) d = SW;
    sh_full = {my, {SW{1'b0}}} >> d;
    my_sh   = sh_full[2*SW-1:SW] | SW'(|sh_full[SW-1:0]);
    sum     = eff_sub ? ({1'b0, mx} - {1'b0, my_sh}) : ({1'b0, mx} + {1'b0, my_sh});

    lz = SW;
    for (int i = 0; i < SW; i++) if (sum[i]) lz = SW - 1 - i;

    exp_r = $signed({2'b00, ex});
    if (sum[SW]) begin
      norm  = sum[SW:1] | SW'(sum[0]);
      exp_r = exp_r + EXP_ONE;
    end else begin
      norm  = sum[SW-1:0] << lz;
      exp_r = exp_r - $signed((EW+2)'(lz));
    end

    grs      = norm[RB-1:0];
    grs_rest = grs << 1;
    round_up = (ROUND_TO_NEAREST != 0) && grs[RB-1] && ((grs_rest != '0) || norm[RB]);
    mant_r   = {1'b0, norm[SW-1:RB]} + (MW+2)'(round_up);
    if (mant_r[MW+1]) exp_r = exp_r + EXP_ONE;
    frac = mant_r[MW+1] ? '0 : mant_r[MW-1:0];

    out       = {sx, exp_r[EW-1:0], frac};
    invalid   = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      out     = {1'b1, EXP_MAX, 1'b1, {(MW-1){1'b0}}};
      invalid = 1'b1;
    end else if (a_inf || b_inf) begin
      out = {a_inf ? sa : sb, EXP_MAX, {MW{1'b0}}};
    end else if (sum == '0) begin
      out = '0;
    end else if (exp_r >= $signed({2'b00, EXP_MAX})) begin
      out      = {sx, EXP_MAX, {MW{1'b0}}};
      overflow = 1'b1;
    end else if (exp_r <= 0) begin
      out       = {sx, {(EW+MW){1'b0}}};
      underflow = 1'b1;
    end
  end

endmodule

// File: rtl/fp_adder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 any_req
);
  localparam int IDW = $clog2(N);

  int             idx;
  logic [IDW-1:0] idx_w;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any_req  = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_w = IDW'(idx);
      if (!any_req && req[idx_w]) begin
        any_req      = 1'b1;
        grant[idx_w] = 1'b1;
        grant_id     = idx_w;
      end
    end
  end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Round-robin sharing of one FP adder among NUM_REQUESTERS clients, one op in flight.
// Optional per-client sticky flags: FP_ADDER_ARBITER_STICKY_FLAGS_EN.
//   state   | meaning
//   IDLE    | scan requests, accept the round-robin winner
//   COMPUTE | adder driven from latched operands, result captured at the edge
//   RESPOND | result presented to the granted client until it accepts
module fp_adder_arbiter
  import fp_adder_arbiter_pkg::*;
#(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1,
  parameter int ROUNDING_BITS    = 3,
  parameter int NUM_REQUESTERS   = 4,
  localparam int W = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQUESTERS-1:0]   req_valid,
  output logic [NUM_REQUESTERS-1:0]   req_ready,
  input  logic [NUM_REQUESTERS*W-1:0] req_a,
  input  logic [NUM_REQUESTERS*W-1:0] req_b,
  input  logic [NUM_REQUESTERS-1:0]   req_subtract,
  output logic [NUM_REQUESTERS-1:0]   resp_valid,
  input  logic [NUM_REQUESTERS-1:0]   resp_ready,
  output logic [W-1:0]                resp_out,
`ifdef FP_ADDER_ARBITER_STICKY_FLAGS_EN
  input  logic                        clear_sticky,
  output logic [3*NUM_REQUESTERS-1:0] sticky_flags,
`endif
  output logic [2:0]                  resp_flags
);
  localparam int IDW = $clog2(NUM_REQUESTERS);

  state_t                    state;
  logic [IDW-1:0]            rr_ptr, grant_id, arb_id;
  logic [NUM_REQUESTERS-1:0] arb_grant;
  logic                      arb_any, op_sub, resp_hs;
  logic [W-1:0]              op_a, op_b, res_out, add_out;
  logic                      add_inv, add_ovf, add_unf;
  fp_add_flags_t             res_flags;

  rr_arbiter #(.N(NUM_REQUESTERS)) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .any_req  (arb_any)
  );

  floating_point_adder #(
    .EXPONENT_WIDTH   (EXPONENT_WIDTH),
    .MANTISSA_WIDTH   (MANTISSA_WIDTH),
    .ROUND_TO_NEAREST (ROUND_TO_NEAREST),
    .ROUNDING_BITS    (ROUNDING_BITS)
  ) u_add (
    .a         (op_a),
    .b         (op_b),
    .subtract  (op_sub),
    .out       (add_out),
    .invalid   (add_inv),
    .overflow  (add_ovf),
    .underflow (add_unf)
  );

  assign req_ready  = (state == IDLE) ? arb_grant : '0;
  assign resp_valid = (state == RESPOND) ? (NUM_REQUESTERS'(1) << grant_id) : '0;
  assign resp_hs    = (state == RESPOND) && resp_ready[grant_id];
  assign resp_out   = res_out;
  assign resp_flags = res_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_sub    <= 1'b0;
      res_out   <= '0;
      res_flags <= '0;
    end else begin
      case (state)
        IDLE: if (arb_any) begin
          op_a     <= req_a[arb_id*W +: W];
          op_b     <= req_b[arb_id*W +: W];
          op_sub   <= req_subtract[arb_id];
          grant_id <= arb_id;
          state    <= COMPUTE;
        end
        COMPUTE: begin
          res_out   <= add_out;
          res_flags <= {add_inv, add_ovf, add_unf};
          state     <= RESPOND;
        end
        RESPOND: if (resp_hs) begin
          rr_ptr <= IDW'(next_rr_index(int'(grant_id), NUM_REQUESTERS));
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_ADDER_ARBITER_STICKY_FLAGS_EN
  // Clear has priority over a coinciding response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_flags <= '0;
    else if (clear_sticky)
      sticky_flags <= '0;
    else if (resp_hs)
      sticky_flags[grant_id*3 +: 3] <= sticky_flags[grant_id*3 +: 3] | res_flags;
  end
`endif

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed-vector bench for fp_adder_arbiter with hand-computed results.
module tb_fp_adder_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, req_subtract, resp_valid, resp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   resp_out;
  logic [2:0]     resp_flags;
`ifdef FP_ADDER_ARBITER_STICKY_FLAGS_EN
  logic [3*N-1:0] sticky_flags;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_adder_arbiter #(.NUM_REQUESTERS(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_subtract (req_subtract),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_out     (resp_out),
`ifdef FP_ADDER_ARBITER_STICKY_FLAGS_EN
    .clear_sticky (1'b0),
    .sticky_flags (sticky_flags),
`endif
    .resp_flags   (resp_flags)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int c, input logic [31:0] a, input logic [31:0] b, input logic sub);
    req_a[c*W +: W]  = a;
    req_b[c*W +: W]  = b;
    req_subtract[c]  = sub;
  endtask

  // Called with the client's request being accepted at the next edge.
  task automatic run_granted(input int c, input logic [31:0] exp_out, input logic [2:0] exp_flags);
    tick();
    req_valid[c] = 1'b0;
    #1;
    check_val("compute_no_resp", 32'(resp_valid), 32'd0);
    tick();
    check_val("resp_valid", 32'(resp_valid), 32'(1 << c));
    check_val("resp_out", resp_out, exp_out);
    check_val("resp_flags", 32'(resp_flags), 32'(exp_flags));
    tick();
    check_val("resp_done", 32'(resp_valid), 32'd0);
  endtask

  task automatic do_single(input int c, input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic [31:0] exp_out, input logic [2:0] exp_flags);
    req_valid  = '0;
    resp_ready = '1;
    set_op(c, a, b, sub);
    req_valid[c] = 1'b1;
    #1;
    check_val("single_ready", 32'(req_ready), 32'(1 << c));
    run_granted(c, exp_out, exp_flags);
  endtask

  task automatic apply_reset();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    req_subtract = '0;
    req_a        = '0;
    req_b        = '0;
    resp_ready   = '0;
    tick();
    tick();
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst_resp_out", resp_out, 32'd0);
    check_val("rst_resp_flags", 32'(resp_flags), 32'd0);
    rst_n = 1'b1;
    tick();
    check_val("idle_no_req", 32'(req_ready), 32'd0);

    // Arithmetic vectors, one client at a time.
    do_single(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 3'b000);
    do_single(1, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 32'hFFC0_0000, 3'b100);
    do_single(2, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b010);
    do_single(3, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'hFFC0_0000, 3'b100);
    do_single(0, 32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 3'b001);
    do_single(1, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3'b000);
    do_single(2, 32'h3F80_0000, 32'hC000_0000, 1'b0, 32'hBF80_0000, 3'b000);
    do_single(3, 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3'b000);
    do_single(0, 32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001, 3'b000);

    // All clients requesting: strict rotation, a new grant every 3 cycles.
    apply_reset();
    for (int c = 0; c < N; c++) set_op(c, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    req_valid  = '1;
    resp_ready = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      check_val("rr_grant", 32'(req_ready), 32'(1 << (g % N)));
      tick();
      tick();
      check_val("rr_resp_valid", 32'(resp_valid), 32'(1 << (g % N)));
      check_val("rr_resp_out", resp_out, 32'h4000_0000);
      check_val("rr_no_ready", 32'(req_ready), 32'd0);
      tick();
    end

    // Backpressure on client 2 while client 3 waits; rr_ptr is now 1.
    req_valid  = 4'b1100;
    resp_ready = 4'b1011;
    #1;
    check_val("bp_grant2", 32'(req_ready), 32'h4);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check_val("bp_valid", 32'(resp_valid), 32'h4);
      check_val("bp_out", resp_out, 32'h4000_0000);
      check_val("bp_no_ready", 32'(req_ready), 32'd0);
      tick();
    end
    resp_ready[2] = 1'b1;
    tick();
    check_val("bp_next3", 32'(req_ready), 32'h8);
    tick();
    tick();
    check_val("bp_resp3", 32'(resp_valid), 32'h8);
    tick();
    check_val("bp_then2", 32'(req_ready), 32'h4);
    req_valid = '0;
    #1;

    // Reset during COMPUTE: client 1 served first so rr_ptr is non-zero before reset.
    do_single(1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 3'b000);
    set_op(2, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    req_valid = 4'b0100;
    #1;
    check_val("mid_grant2", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(resp_valid), 32'd0);
    check_val("mid_rst_out", resp_out, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("post_rst_quiet", 32'(resp_valid), 32'd0);
    end
    set_op(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
    req_valid = 4'b0101;
    #1;
    check_val("post_rst_grant0", 32'(req_ready), 32'h1);
    run_granted(0, 32'h4000_0000, 3'b000);
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
